pipelined_datapath: RTL
=======================

# pipelined_datapath

Parametrised three-stage (Decode, Execute, Writeback) processor datapath that owns the program counter, register file, immediate extender, ALU and the pipeline registers between stages. Compared with the single decode/execute register datapath, branches resolve in Execute with a one-cycle flush, and Writeback-to-Execute operand forwarding is included. A ready-handshaked data-memory port stalls the pipeline. It sits between the external instruction memory and control unit (which decode `inst[23:20]` combinationally) and the external data memory.

## Interface
- `DATA_W`, 24: register, ALU and memory data width.
- `PC_W`, 16: program counter width; must be ≤ `DATA_W`.
- `REG_AW`, 4: register address width; register file holds 2^`REG_AW` entries.
- `IMM_W`, 12: immediate field width taken from `inst[IMM_W-1:0]`.
- `clk`  in  1  single clock; everything is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc`  out  `PC_W`  fetch address; `inst` is the word at `pc` in the same cycle.
- `inst`  in  `DATA_W`  fields: rd=[19:16], rn=[15:12], rm=[11:8], imm=[IMM_W-1:0].
- `reg_write`, `alu_src`, `mem_to_reg`, `mem_write`, `mem_read`, `branch`, `imm_signed`, `st_src`  in  1 each  Decode-stage controls for `inst`.
- `alu_control`  in  2  00 add, 01 sub, 10 and, 11 or.
- `mem_req`  out  1  Execute-stage memory access pending.
- `mem_we`  out  1  1 means store, 0 means load; valid while `mem_req`.
- `mem_addr`  out  `DATA_W`  ALU result.
- `mem_wdata`  out  `DATA_W`  forwarded second operand.
- `mem_rdata`  in  `DATA_W`  load data; sampled when `mem_req & mem_ready & ~mem_we`.
- `mem_ready`  in  1  completes the access this cycle.
- `flags`  out  4  {N,Z,C,V} of the current Execute ALU operation.
- `stall`  out  1  `mem_req & ~mem_ready`.
- `wb_valid`, `wb_addr`, `wb_data`  out  1/`REG_AW`/`DATA_W`  retire port for the Writeback register write.

## Operation
- **Decode.**
  - ra1 = rn.
  - ra2 = `st_src` ? rd : rm, so stores read their data register.
  - Immediate is sign- or zero-extended to `DATA_W` according to `imm_signed`.
  - Register reads are combinational and write-through: if Writeback writes the register being read in the same cycle, the new value is returned.
- **D/E register.** Captures operands, extended immediate, rd, controls and a valid bit.
- **Execute.**
  - Operand A and B are each replaced by `wb_data` when `wb_valid` is set, the Writeback instruction writes a register, and its address matches the operand source.
  - srcB = `alu_src` ? imm : operand B.
  - add/sub are `DATA_W`-bit, wrap modulo 2^`DATA_W`.
  - C is carry-out; for sub, C = no-borrow.
  - V is signed overflow. C and V are 0 for and/or.
  - N is the result MSB. Z means result == 0.
- **Memory.** `mem_req` = E.valid & (`mem_read` | `mem_write`).
- **Branch.**
  - A valid E-stage `branch` is taken unconditionally.
  - On the next edge, `pc` ← `aluRes[PC_W-1:0]` and the D/E register loads a bubble (the instruction fetched behind the branch is squashed).
  - A branch does not write a register unless `reg_write` is set.
- **E/W register.**
  - Captures the result (`mem_rdata` if load, else ALU result), rd, `reg_write` and valid.
  - `wb_valid` = W.valid & W.reg_write.
  - The register file is written at the edge ending Writeback.
- **Stall.** While `stall` is high:
  - `pc` and D/E hold.
  - E/W loads a bubble.
  - No branch is taken.
  - A store is not re-counted: the access completes exactly once, in the `mem_ready` cycle.
- **Precedence.** Reset > stall > branch flush > normal advance.
- **Invalid stages.** Bubbles never assert `mem_req`, never write registers and never branch.
- **`pc` increment.** `pc` + 1 wraps at 2^`PC_W`.

## Timing
- **Reset values.** While `rst` is low:
  - `pc`=0.
  - Both pipeline valid bits are 0.
  - All registers are 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `flags`=0000, `stall`=0, `wb_valid`=0, `wb_addr`=0, `wb_data`=0.
- **Reset in flight.** Reset deasserted mid-operation discards all in-flight instructions. The first fetch after reset is `pc`=0.
- **Latency.**
  - An instruction is in Decode in cycle t, Execute in t+1 and Writeback in t+2.
  - Its register write is visible to a Decode read in cycle t+2, through write-through.
- **Dependencies.**
  - A dependent instruction issued back-to-back receives forwarded data in Execute with no stall.
  - A load followed by a user needs no stall.
- **Branch penalty.** Exactly one bubble. The target enters Decode in cycle t+2 for a branch in Decode at t.
- **Memory stall.** Each wait cycle with `mem_ready`=0 adds one cycle. `mem_ready` while `mem_req`=0 is ignored.

## Test plan
- **Reset.** Hold `rst`=0 for 3 cycles with random inputs → `pc`=0, `mem_req`=0, `wb_valid`=0. After release, `pc` reads 0,1,2.
- **Forwarding.** `add r1=r0+imm 5`, then `add r2=r1+imm 3` back-to-back → `wb_data`=5 then 8. Sub of 0−1 gives `flags`=N1 Z0 C0 V0, result 0xFFFFFF.
- **Overflow.** 0x7FFFFF + 1 → result 0x800000, V=1, N=1. Immediate 0xFFF with `imm_signed`=1 → 0xFFFFFF; with `imm_signed`=0 → 0x000FFF.
- **Branch.** Branch to 0x0040 at `pc`=3 → the instruction at `pc`=4 never retires or accesses memory. `pc` sequence is 3,4,0x40,0x41.
- **Store then load.** Store r1 (=0x123456) to address 10 with `mem_ready` low for 2 cycles → `stall`=1 for exactly 2 cycles, one write with `mem_wdata`=0x123456, and `pc` frozen. A load from address 10 (bench returns 0x123456), followed by a dependent add +1 → `wb_data`=0x123457.
- **Reset during stall.** Assert `rst` during a stall → `mem_req` drops immediately and no write retires.

Source files
------------

// File: rtl/pipelined_datapath_if.sv
// Data-memory port of the pipelined datapath: one request/ready handshake
// carrying a single load or store per accepted cycle.
interface pipelined_datapath_if #(
  parameter int DATA_W = 24
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // datapath side issues requests
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // memory side answers them
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/pipelined_datapath.sv
// Three-stage (Decode / Execute / Writeback) datapath: PC, register file,
// immediate extender, ALU, D/E and E/W pipeline registers, WB->EX forwarding,
// branch resolution in Execute with a one-bubble flush, and stall on a
// data-memory access that is not yet ready.
module pipelined_datapath #(
  parameter int DATA_W = 24,
  parameter int PC_W   = 16,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PC_W-1:0]       pc,
  input  logic [DATA_W-1:0]     inst,
  input  logic                  reg_write,
  input  logic                  alu_src,
  input  logic                  mem_to_reg,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic                  branch,
  input  logic                  imm_signed,
  input  logic                  st_src,
  input  logic [1:0]            alu_control,
  pipelined_datapath_if.master  dmem,
  output logic [3:0]            flags,
  output logic                  stall,
  output logic                  wb_valid,
  output logic [REG_AW-1:0]     wb_addr,
  output logic [DATA_W-1:0]     wb_data
);

  localparam int NREG = 1 << REG_AW;
  localparam int MSB  = DATA_W - 1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic              reg_write;
    logic              alu_src;
    logic              mem_to_reg;
    logic              mem_write;
    logic              mem_read;
    logic              branch;
    logic [1:0]        alu_ctl;
  } de_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } ew_t;

  logic [PC_W-1:0]   pc_q, pc_d;
  de_t               de_q, de_d, de_in_s;
  ew_t               ew_q, ew_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic [REG_AW-1:0] ra1_s, ra2_s;
  logic [DATA_W-1:0] fwd_a_s, fwd_b_s, src_b_s, alu_res_s;
  logic [DATA_W:0]   sum_s;
  logic              flag_c_s, flag_v_s;
  logic              mem_req_s, stall_s, take_branch_s;
  logic              unused_inst_s;

  // opcode bits are decoded by the external control unit, not here
  assign unused_inst_s = ^inst[DATA_W-1:20];

  assign wb_valid = ew_q.valid & ew_q.reg_write;
  assign wb_addr  = ew_q.rd;
  assign wb_data  = ew_q.data;
  assign pc       = pc_q;

  // Decode: field extraction, write-through register reads, immediate extension
  always_comb begin
    ra1_s = inst[12 +: REG_AW];
    ra2_s = st_src ? inst[16 +: REG_AW] : inst[8 +: REG_AW];
    de_in_s            = de_q;
    de_in_s.valid      = 1'b1;
    de_in_s.ra1        = ra1_s;
    de_in_s.ra2        = ra2_s;
    de_in_s.rd         = inst[16 +: REG_AW];
    de_in_s.a          = (wb_valid && (wb_addr == ra1_s)) ? wb_data : regs_q[ra1_s];
    de_in_s.b          = (wb_valid && (wb_addr == ra2_s)) ? wb_data : regs_q[ra2_s];
    if (imm_signed) begin
      de_in_s.imm = {{(DATA_W-IMM_W){inst[IMM_W-1]}}, inst[IMM_W-1:0]};
    end else begin
      de_in_s.imm = {{(DATA_W-IMM_W){1'b0}}, inst[IMM_W-1:0]};
    end
    de_in_s.reg_write  = reg_write;
    de_in_s.alu_src    = alu_src;
    de_in_s.mem_to_reg = mem_to_reg;
    de_in_s.mem_write  = mem_write;
    de_in_s.mem_read   = mem_read;
    de_in_s.branch     = branch;
    de_in_s.alu_ctl    = alu_control;
  end

  // Execute operand selection with Writeback forwarding
  always_comb begin
    fwd_a_s = (wb_valid && (wb_addr == de_q.ra1)) ? wb_data : de_q.a;
    fwd_b_s = (wb_valid && (wb_addr == de_q.ra2)) ? wb_data : de_q.b;
    src_b_s = de_q.alu_src ? de_q.imm : fwd_b_s;
  end

  // ALU and its carry/overflow flags; logic ops clear C and V
  always_comb begin
    sum_s     = {(DATA_W+1){1'b0}};
    alu_res_s = {DATA_W{1'b0}};
    flag_c_s  = 1'b0;
    flag_v_s  = 1'b0;
    case (de_q.alu_ctl)
      2'b00: begin
        sum_s     = {1'b0, fwd_a_s} + {1'b0, src_b_s};
        alu_res_s = sum_s[DATA_W-1:0];
        flag_c_s  = sum_s[DATA_W];
        flag_v_s  = (fwd_a_s[MSB] == src_b_s[MSB]) && (alu_res_s[MSB] != fwd_a_s[MSB]);
      end
      2'b01: begin
        // carry out of a + ~b + 1 is the no-borrow indication
        sum_s     = {1'b0, fwd_a_s} + {1'b0, ~src_b_s} + {{DATA_W{1'b0}}, 1'b1};
        alu_res_s = sum_s[DATA_W-1:0];
        flag_c_s  = sum_s[DATA_W];
        flag_v_s  = (fwd_a_s[MSB] != src_b_s[MSB]) && (alu_res_s[MSB] != fwd_a_s[MSB]);
      end
      2'b10: alu_res_s = fwd_a_s & src_b_s;
      2'b11: alu_res_s = fwd_a_s | src_b_s;
      default: alu_res_s = {DATA_W{1'b0}};
    endcase
  end

  assign mem_req_s     = de_q.valid & (de_q.mem_read | de_q.mem_write);
  assign stall_s       = mem_req_s & ~dmem.mem_ready;
  assign take_branch_s = de_q.valid & de_q.branch & ~stall_s;

  assign dmem.mem_req   = mem_req_s;
  assign dmem.mem_we    = de_q.valid & de_q.mem_write;
  assign dmem.mem_addr  = alu_res_s;
  assign dmem.mem_wdata = fwd_b_s;
  assign stall          = stall_s;
  assign flags          = de_q.valid ? {alu_res_s[MSB], (alu_res_s == {DATA_W{1'b0}}), flag_c_s, flag_v_s}
                                     : 4'b0000;

  // Pipeline advance: stall holds PC/D-E, branch flushes D-E, otherwise step
  always_comb begin
    pc_d           = pc_q;
    de_d           = de_q;
    ew_d.valid     = de_q.valid;
    ew_d.reg_write = de_q.reg_write;
    ew_d.rd        = de_q.rd;
    ew_d.data      = de_q.mem_to_reg ? dmem.mem_rdata : alu_res_s;
    if (stall_s) begin
      // the producer leaves Writeback during the stall, so keep its value here
      de_d.a         = fwd_a_s;
      de_d.b         = fwd_b_s;
      ew_d.valid     = 1'b0;
      ew_d.reg_write = 1'b0;
    end else if (take_branch_s) begin
      pc_d       = alu_res_s[PC_W-1:0];
      de_d       = de_in_s;
      de_d.valid = 1'b0;
    end else begin
      pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      de_d = de_in_s;
    end
  end

  // Register file write at the end of Writeback
  always_comb begin
    regs_d = regs_q;
    if (wb_valid) begin
      regs_d[wb_addr] = wb_data;
    end else begin
      regs_d = regs_q;
    end
  end

  // State registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= {PC_W{1'b0}};
      de_q <= {$bits(de_t){1'b0}};
      ew_q <= {$bits(ew_t){1'b0}};
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      pc_q   <= pc_d;
      de_q   <= de_d;
      ew_q   <= ew_d;
      regs_q <= regs_d;
    end
  end

endmodule
